// File: rtl/mm_spart.sv
// Memory-mapped 8N1 serial port: TX holding register + shifter, RX with
// 2-flop synchronizer and mid-bit sampling, programmable divisor, status.
module mm_spart #(
  parameter logic [15:0] BASE_ADDR   = 16'hC000,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        mm_we,
  input  logic        mm_re,
  output logic [15:0] rdata,
  input  logic        rxd,
  output logic        txd,
  output logic [1:0]  dbg_tx_state,
  output logic [2:0]  dbg_rx_state
);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  logic        w_hit;
  logic [1:0]  w_off;
  logic        w_wr_data, w_wr_stat, w_wr_div, w_rd_data, w_tx_accept;

  logic [15:0] r_div;
  logic [7:0]  r_tx_hold;
  logic        r_tx_full;
  tx_state_t   r_tx_state, w_tx_next;
  logic [15:0] r_tx_cnt;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_shift, w_tx_shift_next;
  logic        r_txd, w_txd_next, w_tx_load, w_tx_tick, w_tx_busy;

  logic        r_rx_s1, r_rx_s2;
  rx_state_t   r_rx_state, w_rx_next;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift, r_rx_byte;
  logic        r_rx_valid, r_rx_ovr, r_frame_err;
  logic        w_rx_tick, w_rx_sample, w_rx_done, w_rx_ferr;

  assign w_hit       = (addr[15:2] == BASE_ADDR[15:2]);
  assign w_off       = addr[1:0];
  assign w_wr_data   = w_hit & mm_we & (w_off == 2'd0);
  assign w_wr_stat   = w_hit & mm_we & (w_off == 2'd1);
  assign w_wr_div    = w_hit & mm_we & (w_off == 2'd2);
  assign w_rd_data   = w_hit & mm_re & (w_off == 2'd0);
  // DATA write is a valid/ready handshake: the byte is taken only when the
  // holding register was empty before the edge (tx_ready), else dropped.
  assign w_tx_accept = w_wr_data & ~r_tx_full;

  assign txd          = r_txd;
  assign dbg_tx_state = r_tx_state;
  assign dbg_rx_state = r_rx_state;

  // ---------------- TX FSM ----------------
  assign w_tx_tick = (r_tx_cnt == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= 16'd0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'd0;
      r_txd      <= 1'b1;
      r_tx_full  <= 1'b0;
      r_tx_hold  <= 8'd0;
    end else begin
      r_tx_state <= w_tx_next;
      r_tx_shift <= w_tx_shift_next;
      r_txd      <= w_txd_next;
      if (w_tx_load || (r_tx_state != TX_IDLE && w_tx_tick))
        r_tx_cnt <= r_div;
      else if (r_tx_state != TX_IDLE)
        r_tx_cnt <= r_tx_cnt - 16'd1;
      if (w_tx_load)
        r_tx_bit <= 3'd0;
      else if (r_tx_state == TX_DATA && w_tx_tick)
        r_tx_bit <= r_tx_bit + 3'd1;
      if (w_tx_load)
        r_tx_full <= 1'b0;
      else if (w_tx_accept)
        r_tx_full <= 1'b1;
      if (w_tx_accept)
        r_tx_hold <= wdata[7:0];
    end
  end

  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_load = 1'b0;
    case (r_tx_state)
      TX_IDLE:  if (r_tx_full) begin
                  w_tx_load = 1'b1;
                  w_tx_next = TX_START;
                end
      TX_START: if (w_tx_tick) w_tx_next = TX_DATA;
      TX_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_next = TX_STOP;
      TX_STOP:  if (w_tx_tick) begin
                  // Chain straight into the next start bit with no idle bit.
                  if (r_tx_full) begin
                    w_tx_load = 1'b1;
                    w_tx_next = TX_START;
                  end else begin
                    w_tx_next = TX_IDLE;
                  end
                end
      default:  w_tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    w_tx_shift_next = r_tx_shift;
    if (w_tx_load)
      w_tx_shift_next = r_tx_hold;
    else if (r_tx_state == TX_DATA && w_tx_tick)
      w_tx_shift_next = {1'b0, r_tx_shift[7:1]};
    case (w_tx_next)
      TX_START: w_txd_next = 1'b0;
      TX_DATA:  w_txd_next = w_tx_shift_next[0];
      default:  w_txd_next = 1'b1;
    endcase
    w_tx_busy = (r_tx_state != TX_IDLE);
  end

  // ---------------- RX FSM ----------------
  assign w_rx_tick = (r_rx_cnt == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= 16'd0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'd0;
    end else begin
      r_rx_s1    <= rxd;
      r_rx_s2    <= r_rx_s1;
      r_rx_state <= w_rx_next;
      case (r_rx_state)
        RX_IDLE:                    r_rx_cnt <= {1'b0, r_div[15:1]};
        RX_START, RX_DATA, RX_STOP: r_rx_cnt <= w_rx_tick ? r_div : r_rx_cnt - 16'd1;
        default:                    r_rx_cnt <= r_rx_cnt;
      endcase
      if (r_rx_state == RX_START)
        r_rx_bit <= 3'd0;
      else if (w_rx_sample)
        r_rx_bit <= r_rx_bit + 3'd1;
      if (w_rx_sample)
        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
    end
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (!r_rx_s2) w_rx_next = RX_START;
      RX_START: if (w_rx_tick) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
      RX_STOP:  if (w_rx_tick) w_rx_next = r_rx_s2 ? RX_IDLE : RX_BREAK;
      RX_BREAK: if (r_rx_s2) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    w_rx_sample = (r_rx_state == RX_DATA) && w_rx_tick;
    w_rx_done   = (r_rx_state == RX_STOP) && w_rx_tick && r_rx_s2;
    w_rx_ferr   = (r_rx_state == RX_STOP) && w_rx_tick && !r_rx_s2;
  end

  // ---------------- Registers and status ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div       <= DEFAULT_DIV;
      r_rx_byte   <= 8'd0;
      r_rx_valid  <= 1'b0;
      r_rx_ovr    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_wr_div)
        r_div <= (wdata < 16'd3) ? 16'd3 : wdata;
      if (w_rx_done)
        r_rx_byte <= r_rx_shift;
      // New byte beats a concurrent DATA read; error sets beat clears.
      if (w_rx_done)
        r_rx_valid <= 1'b1;
      else if (w_rd_data)
        r_rx_valid <= 1'b0;
      if (w_rx_done && r_rx_valid && !w_rd_data)
        r_rx_ovr <= 1'b1;
      else if (w_wr_stat && wdata[2])
        r_rx_ovr <= 1'b0;
      if (w_rx_ferr)
        r_frame_err <= 1'b1;
      else if (w_wr_stat && wdata[3])
        r_frame_err <= 1'b0;
    end
  end

  always_comb begin
    rdata = 16'h0000;
    if (w_hit && mm_re) begin
      case (w_off)
        2'd0:    rdata = {8'h00, r_rx_byte};
        2'd1:    rdata = {11'b0, w_tx_busy, r_frame_err, r_rx_ovr, r_rx_valid, ~r_tx_full};
        2'd2:    rdata = r_div;
        default: rdata = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_spart.sv
// Bench for mm_spart: register vector table, TX frame monitor with an
// expected-byte queue, RX frame driver with an expected-byte queue.
module tb_mm_spart;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr, wdata, rdata;
  logic        mm_we, mm_re, rxd, txd;
  logic [1:0]  dbg_tx_state;
  logic [2:0]  dbg_rx_state;

  mm_spart dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .mm_we(mm_we),
    .mm_re(mm_re), .rdata(rdata), .rxd(rxd), .txd(txd),
    .dbg_tx_state(dbg_tx_state), .dbg_rx_state(dbg_rx_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // ---------------- scoreboards ----------------
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int         tx_start_q[$];
  int         tx_frames = 0;
  int         div_p = 435;

  // TX monitor: every low txd seen at a negedge while idle starts a frame.
  int         mon_p, mon_bad;
  logic [7:0] mon_got, mon_exp;
  logic [9:0] mon_fr;
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && txd === 1'b0) begin
        mon_p = div_p;
        mon_bad = 0;
        mon_got = 8'h00;
        tx_start_q.push_back(cyc);
        check("tx_frame_expected", (tx_q.size() > 0), 1);
        mon_exp = (tx_q.size() > 0) ? tx_q.pop_front() : 8'h00;
        mon_fr = {1'b1, mon_exp, 1'b0};
        for (int i = 0; i < 10 * mon_p; i++) begin
          if (i > 0) @(negedge clk);
          if (txd !== mon_fr[i / mon_p]) mon_bad++;
          if ((i % mon_p) == (mon_p / 2) && (i / mon_p) >= 1 && (i / mon_p) <= 8)
            mon_got[(i / mon_p) - 1] = txd;
        end
        check("tx_frame_byte", mon_got, mon_exp);
        check("tx_frame_bit_timing_errs", mon_bad, 0);
        tx_frames++;
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    addr = a; wdata = d; mm_we = 1'b1;
    @(negedge clk);
    mm_we = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    addr = a; mm_re = 1'b1;
    #1 d = rdata;
    @(negedge clk);
    mm_re = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [15:0] a, input logic [15:0] e);
    logic [15:0] d;
    bus_read(a, d);
    check(name, d, e);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int p);
    rxd = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (p) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (p) @(negedge clk);
    rxd = 1'b1;
    repeat (p) @(negedge clk);
  endtask

  task automatic wait_tx(input int n);
    for (int i = 0; i < 400 && tx_frames < n; i++) @(negedge clk);
    check("tx_frames_done", tx_frames, n);
  endtask

  // ---------------- register vector table ----------------
  typedef struct {
    bit          we;
    bit          re;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] exp;
  } reg_vec_t;

  reg_vec_t vecs[$];

  function automatic void add_vec(input bit we, input bit re, input logic [15:0] a,
                                  input logic [15:0] d, input logic [15:0] e);
    reg_vec_t v;
    v.we = we; v.re = re; v.a = a; v.d = d; v.exp = e;
    vecs.push_back(v);
  endfunction

  // ---------------- test sequence ----------------
  logic [15:0] rd;
  logic [7:0]  last_rx;
  int          wr_cyc, busy_cnt, fall_cyc, rise_cyc, lat;

  initial begin
    rst = 1'b1; addr = 16'h0; wdata = 16'h0; mm_we = 1'b0; mm_re = 1'b0; rxd = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset_txd", txd, 1);

    // we, re, addr, wdata, expected read
    add_vec(0, 1, 16'hC000, 16'h0000, 16'h0000);   // DATA after reset
    add_vec(0, 1, 16'hC001, 16'h0000, 16'h0001);   // STATUS after reset
    add_vec(0, 1, 16'hC002, 16'h0000, 16'd434);    // DIV reset value
    add_vec(0, 1, 16'hC003, 16'h0000, 16'h0000);   // reserved
    add_vec(1, 0, 16'hC002, 16'h0001, 16'h0000);
    add_vec(0, 1, 16'hC002, 16'h0000, 16'h0003);   // clamp 1 -> 3
    add_vec(1, 0, 16'hC002, 16'h0002, 16'h0000);
    add_vec(0, 1, 16'hC002, 16'h0000, 16'h0003);   // clamp 2 -> 3
    add_vec(1, 0, 16'hC002, 16'h0004, 16'h0000);
    add_vec(0, 1, 16'hC002, 16'h0000, 16'h0004);   // 4 stored as-is
    add_vec(1, 0, 16'hC004, 16'h00AA, 16'h0000);   // outside window
    add_vec(0, 1, 16'hC004, 16'h0000, 16'h0000);
    add_vec(0, 1, 16'hC001, 16'h0000, 16'h0001);   // no TX started
    add_vec(1, 0, 16'hC006, 16'h0009, 16'h0000);   // DIV alias outside window
    add_vec(1, 0, 16'hC003, 16'hFFFF, 16'h0000);
    add_vec(0, 1, 16'hC003, 16'h0000, 16'h0000);
    add_vec(0, 1, 16'hC002, 16'h0000, 16'h0004);
    add_vec(0, 0, 16'hC002, 16'h0000, 16'h0000);   // no read strobe
    add_vec(1, 0, 16'hC002, 16'h0003, 16'h0000);
    add_vec(0, 1, 16'hC002, 16'h0000, 16'h0003);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].we) begin
        bus_write(vecs[i].a, vecs[i].d);
      end else if (vecs[i].re) begin
        bus_read(vecs[i].a, rd);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
      end else begin
        addr = vecs[i].a;
        #1 check($sformatf("vec%0d_rdata_nostrobe", i), rdata, vecs[i].exp);
        @(negedge clk);
      end
    end

    // ---- single TX at DIV=3 ----
    div_p = 4;
    tx_start_q.delete();
    tx_q.push_back(8'h55);
    bus_write(16'hC000, 16'h0055);
    wr_cyc = cyc;
    addr = 16'hC001; mm_re = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rdata[4]) busy_cnt++;
      else if (busy_cnt > 0) break;
    end
    mm_re = 1'b0;
    check("tx_busy_clocks", busy_cnt, 40);
    wait_tx(1);
    check("tx_single_frame_count", tx_start_q.size(), 1);
    if (tx_start_q.size() >= 1) check("tx_start_latency", tx_start_q[0] - wr_cyc, 1);

    // ---- back-to-back TX, third write dropped while holding is full ----
    tx_start_q.delete();
    tx_q.push_back(8'hA5);
    bus_write(16'hC000, 16'h00A5);
    rd = 16'h0;
    for (int i = 0; i < 20; i++) begin
      bus_read(16'hC001, rd);
      if (rd[0]) break;
    end
    check("b2b_ready_after_load", rd[0], 1);
    tx_q.push_back(8'h3C);
    bus_write(16'hC000, 16'h003C);
    bus_write(16'hC000, 16'h00FF);
    read_check("b2b_status_full", 16'hC001, 16'h0010);
    wait_tx(3);
    repeat (60) @(negedge clk);
    check("b2b_frame_count", tx_start_q.size(), 2);
    if (tx_start_q.size() >= 2) check("b2b_gap_clocks", tx_start_q[1] - tx_start_q[0], 40);
    check("b2b_tx_q_drained", tx_q.size(), 0);
    read_check("b2b_status_idle", 16'hC001, 16'h0001);

    // ---- RX 8'hC3 with latency measurement ----
    rx_q.push_back(8'hC3);
    addr = 16'hC001; mm_re = 1'b1;
    fall_cyc = cyc;
    rise_cyc = -1;
    fork
      send_frame(8'hC3, 1'b1, 4);
      begin
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (rdata[1]) begin
            rise_cyc = cyc;
            break;
          end
        end
      end
    join
    mm_re = 1'b0;
    lat = rise_cyc - fall_cyc - 1;
    check("rx_latency_within_1", (lat >= 39 && lat <= 41), 1);
    read_check("rx_status_valid", 16'hC001, 16'h0003);
    last_rx = rx_q.pop_front();
    read_check("rx_data_c3", 16'hC000, {8'h00, last_rx});
    read_check("rx_status_cleared", 16'hC001, 16'h0001);

    // ---- overrun ----
    rx_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 4);
    rx_q.push_back(8'h22);
    send_frame(8'h22, 1'b1, 4);
    if (rx_q.size() > 1) void'(rx_q.pop_front());   // older byte overwritten
    read_check("ovr_status", 16'hC001, 16'h0007);
    last_rx = rx_q.pop_front();
    read_check("ovr_data_22", 16'hC000, {8'h00, last_rx});

    // ---- framing error keeps the old byte ----
    send_frame(8'hAA, 1'b0, 4);
    repeat (4) @(negedge clk);
    read_check("ferr_status", 16'hC001, 16'h000D);
    read_check("ferr_byte_kept", 16'hC000, {8'h00, last_rx});
    bus_write(16'hC001, 16'h000C);
    read_check("err_clear_status", 16'hC001, 16'h0001);

    // ---- glitch reject at DIV=7, then a good frame at that rate ----
    bus_write(16'hC002, 16'h0007);
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    read_check("glitch_status", 16'hC001, 16'h0001);
    rx_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 8);
    read_check("rx_div7_status", 16'hC001, 16'h0003);
    last_rx = rx_q.pop_front();
    read_check("rx_div7_data", 16'hC000, {8'h00, last_rx});

    // ---- final report ----
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mm_spart.md
# mm_spart

Memory-mapped serial port (SPART) attached to the CPU's memory-mapped bus, directly downstream of the CPU's `addr`/`wdata`/`mm_we`/`mm_re` outputs and feeding the CPU's `rdata` input. It provides one byte-wide transmit holding register, one receive holding register, a programmable baud divisor and a status register. Serial format is 8N1: one start bit, 8 data bits LSB first, one stop bit, no parity.

## Interface
- `BASE_ADDR`, default 16'hC000: base of the 4-word register window. The block decodes `addr[15:2] == BASE_ADDR[15:2]`.
- `DEFAULT_DIV`, default 16'd434: reset value of the DIV register.
- `clk` in 1: the single clock.
- `rst` in 1: reset. **Synchronous, active-high.**
- `addr` in 16: CPU memory-mapped address.
- `wdata` in 16: CPU write data.
- `mm_we` in 1: write strobe; the write takes effect at the clock edge.
- `mm_re` in 1: read strobe; read side effects take effect at the clock edge.
- `rdata` out 16: read data. Combinational from `addr`. It is 16'h0000 when the address is outside the window or `mm_re` is 0.
- `rxd` in 1: serial input, asynchronous.
- `txd` out 1: serial output, registered.

## Operation
- **Register map (offset = `addr[1:0]`):**
  - 0 DATA:
    - Write: `wdata[7:0]` goes to the TX holding register. It is accepted only if `tx_ready` = 1 in that cycle; otherwise the write is dropped silently.
    - Read: {8'h00, rx_byte}. The `mm_re` edge clears `rx_valid`.
  - 1 STATUS:
    - Read: {11'b0, tx_busy, frame_err, rx_ovr, rx_valid, tx_ready}.
    - Write: a 1 in bit 2 clears `rx_ovr`; a 1 in bit 3 clears `frame_err`. All other bits are ignored.
  - 2 DIV: read/write. The bit period is DIV+1 clocks. Written values below 3 are stored as 3.
  - 3: reserved. Reads return 0; writes are ignored.
- **Reset values:** `txd` = 1, `tx_ready` = 1, `rx_valid` = `rx_ovr` = `frame_err` = `tx_busy` = 0, `rx_byte` = 0, DIV = `DEFAULT_DIV`, both FSMs in IDLE. Reset mid-frame aborts the frame: `txd` is 1 from the cycle after `rst`.
- **TX FSM (IDLE → START → DATA → STOP):**
  - IDLE: if the holding register is full, move the byte to the shifter, free the holding register (`tx_ready` = 1) and go to START.
  - START: drive `txd` = 0 for DIV+1 clocks.
  - DATA: drive 8 bits LSB first, DIV+1 clocks each, with a 3-bit bit counter.
  - STOP: drive `txd` = 1 for DIV+1 clocks. Then, if the holding register is full, load it and go directly to START with no idle bit; else go to IDLE.
  - `tx_busy` = 1 in any state other than IDLE.
- **RX path:** `rxd` passes through a 2-flop synchronizer; it resets to 1.
- **RX FSM (IDLE → START → DATA → STOP):**
  - IDLE: a synced 1→0 transition enters START with the counter loaded to DIV>>1.
  - START: on counter expiry, if synced `rxd` = 0, go to DATA; else return to IDLE (glitch reject).
  - DATA: sample every DIV+1 clocks, 8 samples, shifting LSB first.
  - STOP: sample after DIV+1 clocks.
    - Sample = 1: load `rx_byte` and set `rx_valid`. If `rx_valid` was already 1 and is not being read in that cycle, also set `rx_ovr`; the new byte overwrites the old one.
    - Sample = 0: set `frame_err`, discard the byte, leave `rx_valid` unchanged, and wait for synced `rxd` = 1 before returning to IDLE.
- **Divisor change:** a DIV write mid-frame takes effect at the next bit-counter reload in either FSM.

## Timing
- **Register write:** a write at edge N is visible on the STATUS/DIV read in cycle N+1.
- **TX latency:** a DATA write at edge N with TX idle gives `txd` = 0 starting at edge N+1. The full frame lasts 10·(DIV+1) clocks.
- **Back-to-back TX:** the second frame's start bit begins on the clock immediately after the first frame's last stop-bit clock.
- **RX latency:** `rx_valid` rises 3 + (DIV>>1) + 9·(DIV+1) clocks after the `rxd` falling edge. This is ±1 clock for synchronizer alignment.
- **Simultaneous RX completion and DATA read:** the new byte wins. `rx_valid` stays 1 and `rx_ovr` is not set.
- **Simultaneous STATUS clear-write and error event:** the set wins.
- **Simultaneous DATA write and holding→shifter transfer:** the write is accepted only if `tx_ready` was 1 before the edge. There is no same-cycle bypass.

## Test plan
- **Reset:** assert `rst` for 1 cycle. Then: `txd` = 1; STATUS reads 16'h0001; DIV reads 16'd434; DATA reads 16'h0000.
- **Single TX:** write DIV = 3, then DATA = 16'h0055. Then `txd` = 0 for 4 clocks; bits 1,0,1,0,1,0,1,0 at 4 clocks each; then 1. STATUS bit4 = 1 for exactly 40 clocks.
- **Back-to-back TX:** with DIV = 3, write 16'h00A5. When `tx_ready` = 1, write 16'h003C. While the holding register is full, write 16'h00FF. Required: two contiguous frames (80 clocks, no idle bit); 8'hFF is never transmitted.
- **RX:** with DIV = 3, drive an 8'hC3 frame on `rxd` with 4-clock bits. Then STATUS bit1 = 1; reading DATA returns 16'h00C3; STATUS then reads 16'h0001.
- **RX errors:**
  - Receive 8'h11 then 8'h22 without reading: `rx_ovr` = 1 and DATA = 16'h0022.
  - Send a frame with stop bit = 0: `frame_err` = 1 and `rx_byte` is unchanged.
  - Write STATUS = 16'h000C: both error bits clear.
- **Decode and clamp:**
  - A write to `BASE_ADDR`+4 has no effect, and reading it returns 0.
  - Write DIV = 1: DIV reads back 16'd3.
  - A 2-clock low glitch on `rxd` at DIV = 7 is rejected: no `rx_valid`, no `frame_err`.
